axis_frame_checker: RTL and testbench

- Downstream consumer for the AXIS FIFO output in the FIFO simulation example.
- Drives s_axis_tready from a configurable back-pressure generator.
- Checks every accepted beat against the counter-source frame format: incrementing tdata, all-ones tkeep, tuser on first beat, tlast on beat FRAME_BEATS-1.
- Exposes frame/error counters and sticky error flags for the bench, plus a done flag after NUM_FRAMES good frames.

---
 rtl/axis_chk_pkg.sv | 27 ++
 rtl/axis_bp_gen.sv | 66 ++++++
 rtl/axis_frame_checker.sv | 156 +++++++++++++++
 tb/tb_axis_frame_checker.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/axis_chk_pkg.sv
// Shared types and constants for the AXIS frame checker.
package axis_chk_pkg;

    typedef enum logic [1:0] {
        SOF,
        BODY,
        RESYNC
    } chk_state_e;

    localparam int unsigned ERR_DATA    = 0;
    localparam int unsigned ERR_LAST    = 1;
    localparam int unsigned ERR_KEEP    = 2;
    localparam int unsigned ERR_USER    = 3;
    localparam int unsigned ERR_FLAGS_W = 4;

    localparam int unsigned FRAME_CNT_W = 32;
    localparam int unsigned ERR_CNT_W   = 16;

    // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic lfsr_fb(input logic [15:0] state);
        return ^(state & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/axis_bp_gen.sv
// Registered tready generator: periodic one-in-BP_PERIOD gap, or an LFSR
// pattern when AXIS_CHK_LFSR_BP_EN is defined.
module axis_bp_gen
    import axis_chk_pkg::*;
#(
    parameter int unsigned BP_PERIOD = 4
) (
    input  logic aclk,
    input  logic areset,
    input  logic ready_en,
    output logic ready
);

    logic ready_q, ready_d;
    logic allowed;

`ifdef AXIS_CHK_LFSR_BP_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d  = {lfsr_q[14:0], lfsr_fb(lfsr_q)};
        allowed = (BP_PERIOD == 0) || lfsr_q[0];
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    localparam int unsigned BpW = (BP_PERIOD > 1) ? $clog2(BP_PERIOD) : 1;
    localparam logic [BpW-1:0] BpLast = (BP_PERIOD > 0) ? BpW'(BP_PERIOD - 1) : '0;

    logic [BpW-1:0] bp_cnt_q, bp_cnt_d;

    always_comb begin
        bp_cnt_d = (bp_cnt_q == BpLast) ? '0 : bp_cnt_q + BpW'(1);
        allowed  = (BP_PERIOD == 0) || (bp_cnt_q != BpLast);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            bp_cnt_q <= '0;
        end else begin
            bp_cnt_q <= bp_cnt_d;
        end
    end
`endif

    always_comb begin
        ready_d = ready_en & ~areset & allowed;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;

endmodule

// File: rtl/axis_frame_checker.sv
// AXIS sink that checks counter-source frames and keeps good/error statistics.
// Optional LFSR back-pressure: define AXIS_CHK_LFSR_BP_EN.
module axis_frame_checker
    import axis_chk_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned KEEP_W      = DATA_W / 8,
    parameter int unsigned USER_W      = 1,
    parameter int unsigned FRAME_BEATS = 8,
    parameter int unsigned BP_PERIOD   = 4,
    parameter int unsigned NUM_FRAMES  = 16
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [DATA_W-1:0]      s_axis_tdata,
    input  logic [KEEP_W-1:0]      s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic [USER_W-1:0]      s_axis_tuser,
    input  logic                   ready_en,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic [ERR_CNT_W-1:0]   err_cnt,
    output logic [ERR_FLAGS_W-1:0] err_flags,
    output logic                   done
);

    localparam int unsigned IdxW = $clog2(FRAME_BEATS);

    chk_state_e             state_q, state_d;
    logic [IdxW-1:0]        beat_idx_q, beat_idx_d;
    logic [DATA_W-1:0]      exp_data_q, exp_data_d;
    logic                   frame_err_q, frame_err_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [ERR_FLAGS_W-1:0] err_flags_q, err_flags_d;
    logic                   done_q, done_d;

    logic tready;
    logic xfer, at_end;
    logic data_err, keep_err, user_err, last_err, beat_err;
    logic frame_end, frame_good;

    axis_bp_gen #(
        .BP_PERIOD(BP_PERIOD)
    ) u_bp_gen (
        .aclk    (aclk),
        .areset  (areset),
        .ready_en(ready_en),
        .ready   (tready)
    );

    always_comb begin
        xfer     = s_axis_tvalid & tready;
        at_end   = (beat_idx_q == IdxW'(FRAME_BEATS - 1));
        data_err = (s_axis_tdata != exp_data_q);
        keep_err = (s_axis_tkeep != {KEEP_W{1'b1}});
        user_err = (s_axis_tuser[0] != (state_q == SOF));

        last_err   = 1'b0;
        frame_end  = 1'b0;
        state_d    = state_q;
        beat_idx_d = beat_idx_q;

        unique case (state_q)
            SOF: begin
                if (s_axis_tlast) begin
                    last_err = 1'b1;
                end else begin
                    beat_idx_d = IdxW'(1);
                    state_d    = BODY;
                end
            end
            BODY: begin
                if (s_axis_tlast && at_end) begin
                    frame_end = 1'b1;
                    state_d   = SOF;
                end else if (s_axis_tlast) begin
                    last_err = 1'b1;
                    state_d  = SOF;
                end else if (at_end) begin
                    last_err = 1'b1;
                    state_d  = RESYNC;
                end else begin
                    beat_idx_d = beat_idx_q + IdxW'(1);
                end
            end
            RESYNC: begin
                if (s_axis_tlast) begin
                    state_d = SOF;
                end
            end
            default: state_d = SOF;
        endcase

        beat_err   = data_err | keep_err | user_err | last_err;
        frame_good = frame_end & ~frame_err_q & ~beat_err;

        exp_data_d  = exp_data_q;
        frame_err_d = frame_err_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_flags_d = err_flags_q;

        if (xfer) begin
            // Resync the expected counter to whatever arrived, so one bad beat logs once.
            exp_data_d  = s_axis_tdata + DATA_W'(1);
            frame_err_d = (state_d == SOF) ? 1'b0 : (frame_err_q | beat_err);
            if (frame_good && (frame_cnt_q != '1)) begin
                frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
            end
            if (beat_err && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
            err_flags_d[ERR_DATA] = err_flags_q[ERR_DATA] | data_err;
            err_flags_d[ERR_LAST] = err_flags_q[ERR_LAST] | last_err;
            err_flags_d[ERR_KEEP] = err_flags_q[ERR_KEEP] | keep_err;
            err_flags_d[ERR_USER] = err_flags_q[ERR_USER] | user_err;
        end else begin
            state_d    = state_q;
            beat_idx_d = beat_idx_q;
        end

        done_d = done_q |
                 ((NUM_FRAMES != 0) && (frame_cnt_q == FRAME_CNT_W'(NUM_FRAMES)));
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= SOF;
            beat_idx_q  <= '0;
            exp_data_q  <= '0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            err_flags_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_idx_q  <= beat_idx_d;
            exp_data_q  <= exp_data_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_flags_q <= err_flags_d;
            done_q      <= done_d;
        end
    end

    assign s_axis_tready = tready;
    assign frame_cnt     = frame_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign err_flags     = err_flags_q;
    assign done          = done_q;

endmodule

// File: tb/tb_axis_frame_checker.sv
// Directed bench for axis_frame_checker with default parameters.
module tb_axis_frame_checker;

    localparam int unsigned FB = 8;

    logic        aclk = 1'b0;
    logic        areset;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic [0:0]  s_axis_tuser;
    logic        ready_en;
    logic [31:0] frame_cnt;
    logic [15:0] err_cnt;
    logic [3:0]  err_flags;
    logic        done;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic [31:0] nd;

    axis_frame_checker dut (
        .aclk         (aclk),
        .areset       (areset),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tuser (s_axis_tuser),
        .ready_en     (ready_en),
        .frame_cnt    (frame_cnt),
        .err_cnt      (err_cnt),
        .err_flags    (err_flags),
        .done         (done)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge aclk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input logic u);
        int waited = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        while (!s_axis_tready && waited < 20) begin
            @(negedge aclk);
            waited++;
        end
        if (!s_axis_tready) check("tready_timeout", {31'd0, s_axis_tready}, 32'd1);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        nd = 32'd0;
    endtask

    task automatic check_stats(input string tag, input logic [31:0] fc, input logic [31:0] ec,
                               input logic [31:0] fl);
        check({tag, "_frame_cnt"}, frame_cnt, fc);
        check({tag, "_err_cnt"}, {16'd0, err_cnt}, ec);
        check({tag, "_err_flags"}, {28'd0, err_flags}, fl);
    endtask

    // Scenario id selects which single fault (if any) is planted in the stream.
    task automatic run_frames(input int scen, input int nframes);
        logic [31:0] d;
        logic [3:0]  k;
        logic        l, u;
        int          len;
        for (int f = 0; f < nframes; f++) begin
            len = (scen == 3 && f == 0) ? 6 : FB;
            for (int b = 0; b < len; b++) begin
                d = nd;
                k = 4'hF;
                l = (b == len - 1);
                u = (b == 0);
                if (scen == 2 && f == 3 && b == 2) d = 32'h55;
                if (scen == 4 && f == 0 && b == 7) l = 1'b0;
                if (scen == 5 && f == 0 && b == 3) k = 4'h7;
                if (scen == 5 && f == 1 && b == 0) u = 1'b0;
                send_beat(d, k, l, u);
                nd = d + 32'd1;
                if (scen == 2 && f == 3 && b == 3) begin
                    idle(1);
                    check("s2_err_after_resync", {16'd0, err_cnt}, 32'd1);
                end
            end
            if (scen == 1 && f == 14) begin
                idle(2);
                check("s1_frame_cnt_15", frame_cnt, 32'd15);
                check("s1_done_not_yet", {31'd0, done}, 32'd0);
            end
        end
        idle(3);
    endtask

    initial begin
        areset        = 1'b1;
        ready_en      = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
        nd            = '0;

        // Ideal stream plus reset state and tready pattern.
        @(negedge aclk);
        do_reset();
        check("rst_tready", {31'd0, s_axis_tready}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check_stats("rst", 32'd0, 32'd0, 32'd0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge aclk);
            check($sformatf("bp_tready_%0d", i), {31'd0, s_axis_tready},
                  (i % 4 != 0) ? 32'd1 : 32'd0);
        end
        run_frames(1, 16);
        check_stats("s1", 32'd16, 32'd0, 32'd0);
        check("s1_done", {31'd0, done}, 32'd1);

        // Bad data on frame 3 beat 2.
        do_reset();
        run_frames(2, 16);
        check_stats("s2", 32'd15, 32'd1, 32'h1);
        check("s2_done", {31'd0, done}, 32'd0);

        // Early tlast on beat 5 of frame 0.
        do_reset();
        run_frames(3, 2);
        check_stats("s3", 32'd1, 32'd1, 32'h2);

        // Missing tlast on frame 0: resync through frame 1.
        do_reset();
        run_frames(4, 4);
        check_stats("s4", 32'd2, 32'd2, 32'hA);

        // Partial tkeep and missing SOF tuser.
        do_reset();
        run_frames(5, 3);
        check_stats("s5", 32'd1, 32'd2, 32'hC);

        // Reset mid-frame 4 with ready_en low, then a fresh stream.
        do_reset();
        run_frames(6, 4);
        check("s6_pre_frame_cnt", frame_cnt, 32'd4);
        for (int b = 0; b < 3; b++) begin
            send_beat(nd, 4'hF, 1'b0, b == 0);
            nd = nd + 32'd1;
        end
        ready_en = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("s6_tready_low_%0d", i), {31'd0, s_axis_tready}, 32'd0);
            @(negedge aclk);
        end
        check_stats("s6_rst", 32'd0, 32'd0, 32'd0);
        check("s6_rst_done", {31'd0, done}, 32'd0);
        ready_en = 1'b1;
        run_frames(6, 2);
        check_stats("s6", 32'd2, 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
